instruction_sequencer: RTL and testbench

Upstream issue stage for the tensor-core cpu. It buffers 16-bit instructions from the host in an input FIFO and presents exactly one instruction per clock on current_instruction_out. It inserts NOPs while the tensor core is computing, and when the FIFO is empty. It captures cpu_output on every issued READ into a small result FIFO that the host drains with a valid/ready handshake.

---
 rtl/instruction_sequencer.sv | 145 ++++++++++++++
 tb/tb_instruction_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Issue stage for the tensor-core cpu: buffers host instructions, issues one word per clock,
// pads with NOPs during OPERATE stalls or when starved, and queues READ results for the host.
module instruction_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned BUS_WIDTH     = 8,
  parameter int unsigned OPERATE_STALL = 4,
  parameter int unsigned RESULT_DEPTH  = 2
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   instr_valid_in,
  input  logic [15:0]            instr_data_in,
  output logic                   instr_ready_out,
  output logic [15:0]            current_instruction_out,
  input  logic [BUS_WIDTH-1:0]   cpu_output_in,
  output logic                   result_valid_out,
  output logic [BUS_WIDTH-1:0]   result_data_out,
  input  logic                   result_ready_in,
  output logic                   busy_out,
  output logic [$clog2(DEPTH):0] fifo_level_out
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RAW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int unsigned RCW = $clog2(RESULT_DEPTH + 1);
  localparam int unsigned SCW = (OPERATE_STALL > 0) ? $clog2(OPERATE_STALL + 1) : 1;
  localparam logic [15:0] Nop = 16'h0008;

  typedef enum logic {StIdle, StStall} state_e;

  logic [15:0]          imem_q [DEPTH];
  logic [AW-1:0]        iwr_q, iwr_d, ird_q, ird_d;
  logic [AW:0]          icnt_q, icnt_d;
  logic [BUS_WIDTH-1:0] rmem_q [RESULT_DEPTH];
  logic [RAW-1:0]       rwr_q, rwr_d, rrd_q, rrd_d;
  logic [RCW-1:0]       rcnt_q, rcnt_d;
  state_e               state_q, state_d;
  logic [SCW-1:0]       stall_q, stall_d;
  logic [15:0]          instr_q, instr_d;

  logic [15:0] head;
  logic        i_push, i_pop, i_empty, i_full;
  logic        r_push, r_pop;
  logic        head_is_read, head_is_op, read_in_flight, read_ok;
  logic [RCW:0] r_occ;

  function automatic logic [RAW-1:0] r_inc(input logic [RAW-1:0] p);
    return (p == RAW'(RESULT_DEPTH - 1)) ? '0 : p + RAW'(1);
  endfunction

  assign head           = imem_q[ird_q];
  assign i_empty        = (icnt_q == '0);
  assign i_full         = (icnt_q == (AW + 1)'(DEPTH));
  assign head_is_read   = (head[3:0] == 4'b0000);
  assign head_is_op     = (head[1:0] == 2'b10);
  assign read_in_flight = (instr_q[3:0] == 4'b0000);

  assign r_pop  = (rcnt_q != '0) && result_ready_in;
  assign r_push = read_in_flight;

  // A READ may only issue if its result slot is guaranteed free at capture time.
  assign r_occ   = {1'b0, rcnt_q} + (RCW + 1)'(read_in_flight) - (RCW + 1)'(r_pop);
  assign read_ok = (r_occ < (RCW + 1)'(RESULT_DEPTH));

  assign i_pop           = (state_q == StIdle) && !i_empty && (!head_is_read || read_ok);
  assign instr_ready_out = !i_full || i_pop;
  assign i_push          = instr_valid_in && instr_ready_out;

  always_comb begin
    iwr_d  = iwr_q;
    ird_d  = ird_q;
    icnt_d = icnt_q;
    rwr_d  = rwr_q;
    rrd_d  = rrd_q;
    rcnt_d = rcnt_q;
    if (i_push) iwr_d = iwr_q + AW'(1);
    if (i_pop)  ird_d = ird_q + AW'(1);
    if (i_push && !i_pop)      icnt_d = icnt_q + (AW + 1)'(1);
    else if (!i_push && i_pop) icnt_d = icnt_q - (AW + 1)'(1);
    if (r_push) rwr_d = r_inc(rwr_q);
    if (r_pop)  rrd_d = r_inc(rrd_q);
    if (r_push && !r_pop)      rcnt_d = rcnt_q + RCW'(1);
    else if (!r_push && r_pop) rcnt_d = rcnt_q - RCW'(1);
  end

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    instr_d = Nop;
    unique case (state_q)
      StIdle: begin
        if (i_pop) begin
          instr_d = head;
          // cpu start is level-sensitive, so an OPERATE must be followed by NOPs
          if (head_is_op && (OPERATE_STALL > 0)) begin
            state_d = StStall;
            stall_d = SCW'(OPERATE_STALL);
          end
        end
      end
      StStall: begin
        stall_d = stall_q - SCW'(1);
        if (stall_q == SCW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      iwr_q   <= '0;
      ird_q   <= '0;
      icnt_q  <= '0;
      rwr_q   <= '0;
      rrd_q   <= '0;
      rcnt_q  <= '0;
      state_q <= StIdle;
      stall_q <= '0;
      instr_q <= Nop;
    end else begin
      iwr_q   <= iwr_d;
      ird_q   <= ird_d;
      icnt_q  <= icnt_d;
      rwr_q   <= rwr_d;
      rrd_q   <= rrd_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      stall_q <= stall_d;
      instr_q <= instr_d;
    end
  end

  // Storage needs no reset: entries are only read while the occupancy count covers them.
  always_ff @(posedge clock_in) begin
    if (i_push) imem_q[iwr_q] <= instr_data_in;
    if (r_push) rmem_q[rwr_q] <= cpu_output_in;
  end

  assign current_instruction_out = instr_q;
  assign result_valid_out        = (rcnt_q != '0);
  assign result_data_out         = rmem_q[rrd_q];
  assign busy_out                = !i_empty || (state_q != StIdle) || read_in_flight;
  assign fifo_level_out          = icnt_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_sequencer;

  localparam int DEPTH = 16;
  localparam int RDEPTH = 2;
  localparam int STALL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ivalid = 1'b0;
  logic [15:0] idata = 16'h0;
  logic        rready = 1'b0;
  logic [7:0]  cpu_val = 8'h0;

  logic        instr_ready_out;
  logic [15:0] current_instruction_out;
  logic        result_valid_out;
  logic [7:0]  result_data_out;
  logic        busy_out;
  logic [4:0]  fifo_level_out;

  instruction_sequencer #(
    .DEPTH(DEPTH),
    .BUS_WIDTH(8),
    .OPERATE_STALL(STALL),
    .RESULT_DEPTH(RDEPTH)
  ) dut (
    .clock_in(clk),
    .reset_n_in(rst_n),
    .instr_valid_in(ivalid),
    .instr_data_in(idata),
    .instr_ready_out(instr_ready_out),
    .current_instruction_out(current_instruction_out),
    .cpu_output_in(cpu_val),
    .result_valid_out(result_valid_out),
    .result_data_out(result_data_out),
    .result_ready_in(rready),
    .busy_out(busy_out),
    .fifo_level_out(fifo_level_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction queue, result queue, bus word, remaining stall cycles.
  logic [15:0] iq[$];
  logic [7:0]  rq[$];
  logic [15:0] bus_m = 16'h0008;
  int          stall_m = 0;

  function automatic bit m_can_issue();
    int occ;
    if (stall_m != 0 || iq.size() == 0) return 1'b0;
    if (iq[0][3:0] != 4'h0) return 1'b1;
    occ = rq.size() + ((bus_m[3:0] == 4'h0) ? 1 : 0) - ((rq.size() > 0 && rready) ? 1 : 0);
    return occ < RDEPTH;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit issue, push, rif, rpop;
    if (!rst_n) begin
      iq.delete();
      rq.delete();
      bus_m = 16'h0008;
      stall_m = 0;
    end else begin
      issue = m_can_issue();
      push  = ivalid && (iq.size() < DEPTH || issue);
      rif   = (bus_m[3:0] == 4'h0);
      rpop  = (rq.size() > 0) && rready;
      if (rpop) void'(rq.pop_front());
      if (rif) rq.push_back(cpu_val);
      if (issue) begin
        bus_m = iq.pop_front();
        if (bus_m[1:0] == 2'b10) stall_m = STALL;
      end else begin
        bus_m = 16'h0008;
        if (stall_m > 0) stall_m--;
      end
      if (push) iq.push_back(idata);
    end
  end

  always @(negedge clk) begin
    check("bus", 32'(current_instruction_out), 32'(bus_m));
    check("level", 32'(fifo_level_out), 32'(iq.size()));
    check("ready", 32'(instr_ready_out), 32'((iq.size() < DEPTH) || m_can_issue()));
    check("rvalid", 32'(result_valid_out), 32'(rq.size() > 0));
    if (rq.size() > 0) check("rdata", 32'(result_data_out), 32'(rq[0]));
    check("busy", 32'(busy_out),
          32'((iq.size() > 0) || (stall_m > 0) || (bus_m[3:0] == 4'h0)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    bit acc;
    int n;
    n = 0;
    ivalid = 1'b1;
    idata  = w;
    do begin
      @(negedge clk);
      acc = instr_ready_out;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout: word %0h never accepted", w);
    end
    ivalid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_bus", 32'(current_instruction_out), 32'h0008);
    check("rst_rvalid", 32'(result_valid_out), 32'h0);
    check("rst_level", 32'(fifo_level_out), 32'h0);
    check("rst_ready", 32'(instr_ready_out), 32'h1);
    check("rst_busy", 32'(busy_out), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_bus", 32'(current_instruction_out), 32'h0008);
      check("idle_busy", 32'(busy_out), 32'h0);
    end

    // Load then read
    cpu_val = 8'd5;
    push(16'h1829);
    push(16'h00C0);
    check("ld_bus", 32'(current_instruction_out), 32'h1829);
    tick();
    check("rd_bus", 32'(current_instruction_out), 32'h00C0);
    check("rd_rvalid_early", 32'(result_valid_out), 32'h0);
    tick();
    check("rd_rvalid", 32'(result_valid_out), 32'h1);
    check("rd_rdata", 32'(result_data_out), 32'd5);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rd_popped", 32'(result_valid_out), 32'h0);

    // Operate stall
    cpu_val = 8'hA5;
    push(16'h0002);
    push(16'h00C0);
    check("op_bus", 32'(current_instruction_out), 32'h0002);
    check("op_busy", 32'(busy_out), 32'h1);
    for (int i = 0; i < STALL; i++) begin
      tick();
      check("op_nop", 32'(current_instruction_out), 32'h0008);
      check("op_busy_stall", 32'(busy_out), 32'h1);
    end
    tick();
    check("op_read_bus", 32'(current_instruction_out), 32'h00C0);
    tick();
    check("op_rdata", 32'(result_data_out), 32'hA5);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Result backpressure
    cpu_val = 8'h11;
    push(16'h00C0);
    push(16'h0040);
    push(16'h0080);
    check("bp_bus2", 32'(current_instruction_out), 32'h0040);
    cpu_val = 8'h22;
    tick();
    check("bp_hold0", 32'(current_instruction_out), 32'h0008);
    check("bp_rdata0", 32'(result_data_out), 32'h11);
    tick();
    tick();
    check("bp_hold2", 32'(current_instruction_out), 32'h0008);
    check("bp_level", 32'(fifo_level_out), 32'h1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    cpu_val = 8'h33;
    check("bp_bus3", 32'(current_instruction_out), 32'h0080);
    check("bp_rdata1", 32'(result_data_out), 32'h22);
    tick();
    check("bp_level0", 32'(fifo_level_out), 32'h0);
    rready = 1'b1;
    repeat (2) tick();
    rready = 1'b0;
    check("bp_drained", 32'(result_valid_out), 32'h0);

    // FIFO full: a blocked READ at the head holds the queue
    cpu_val = 8'h44;
    push(16'h00C0);
    push(16'h0040);
    push(16'h0080);
    for (int i = 0; i < 15; i++) push(16'((i << 4) | 1));
    check("full_level", 32'(fifo_level_out), 32'd16);
    ivalid = 1'b1;
    idata  = 16'hBEE1;
    @(negedge clk);
    check("full_ready", 32'(instr_ready_out), 32'h0);
    tick();
    check("full_level_held", 32'(fifo_level_out), 32'd16);
    rready = 1'b1;
    @(negedge clk);
    check("full_ready_pop", 32'(instr_ready_out), 32'h1);
    tick();
    check("full_pushpop_level", 32'(fifo_level_out), 32'd16);
    check("full_pushpop_bus", 32'(current_instruction_out), 32'h0080);
    for (int i = 0; i < 40; i++) push((i == 7) ? 16'h000C : 16'(16'h2001 + (i << 4)));
    repeat (25) tick();
    check("wrap_level", 32'(fifo_level_out), 32'h0);
    check("wrap_bus", 32'(current_instruction_out), 32'h0008);
    rready = 1'b0;

    // Mid-operation reset
    cpu_val = 8'h66;
    push(16'h00C0);
    repeat (2) tick();
    push(16'h0002);
    push(16'h1111);
    push(16'h2221);
    check("mr_rvalid_pre", 32'(result_valid_out), 32'h1);
    check("mr_busy_pre", 32'(busy_out), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_bus", 32'(current_instruction_out), 32'h0008);
    check("mr_rvalid", 32'(result_valid_out), 32'h0);
    check("mr_level", 32'(fifo_level_out), 32'h0);
    check("mr_busy", 32'(busy_out), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_bus", 32'(current_instruction_out), 32'h0008);
      check("post_busy", 32'(busy_out), 32'h0);
      check("post_level", 32'(fifo_level_out), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
